// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 single-path delay-feedback FFT stage: delay-line enable, butterfly/bypass select,
// twiddle addressing and output framing. Output lags input by D shift cycles; in_ready drops only while draining the delay line.
module sdf_stage_ctrl #(
   parameter int N_POINTS = 16,
   parameter int STAGE    = 0,
   parameter int TW_W     = $clog2(N_POINTS) - 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            delay_en,
   output logic            bf_sel,
   output logic [TW_W-1:0] tw_addr,
   output logic            tw_valid,
   output logic            out_valid,
   output logic            frame_done,
   output logic            busy
);

   localparam int CW    = $clog2(N_POINTS);
   localparam int D     = N_POINTS >> (STAGE + 1);
   localparam int LOG2D = $clog2(D);
   localparam int DW    = (LOG2D > 0) ? LOG2D : 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  r_ocnt;
   logic [DW-1:0]  r_dcnt;
   logic           r_in_ready;

   state_t         w_next;
   logic           w_accept;
   logic           w_drain;
   logic           w_run;
   logic           w_fill_done;
   logic           w_dcnt_last;
   logic           w_delay_en;
   logic           w_bf_sel;
   logic           w_out_valid;
   logic           w_tw_valid;
   logic [CW-1:0]  w_tw_raw;

   assign w_accept    = in_valid && r_in_ready;
   assign w_drain     = (r_state == S_DRAIN);
   assign w_run       = (r_state == S_RUN);
   assign w_fill_done = (r_cnt == CW'(D - 1));
   assign w_dcnt_last = (r_dcnt == DW'(D - 1));

   assign w_delay_en  = w_accept || w_drain;
   // cnt bit LOG2D marks the second half of each 2D block, where the butterfly fires
   assign w_bf_sel    = w_accept && r_cnt[LOG2D];
   assign w_out_valid = w_delay_en && (w_run || w_drain);
   assign w_tw_valid  = w_out_valid && !w_bf_sel;
   assign w_tw_raw    = w_drain ? (CW'(r_dcnt) << STAGE)
                                : ((r_cnt & CW'(D - 1)) << STAGE);

   assign in_ready   = r_in_ready;
   assign delay_en   = w_delay_en;
   assign bf_sel     = w_bf_sel;
   assign out_valid  = w_out_valid;
   assign tw_valid   = w_tw_valid;
   assign tw_addr    = w_tw_valid ? TW_W'(w_tw_raw) : '0;
   assign frame_done = w_out_valid && (r_ocnt == CW'(N_POINTS - 1));
   assign busy       = (r_state != S_IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_fill_done ? S_RUN : S_FILL;
         S_FILL:  if (w_accept && w_fill_done) w_next = S_RUN;
         // cnt only returns to 0 in RUN after a frame end; an idle cycle there starts the flush
         S_RUN:   if (!w_accept && (r_cnt == '0)) w_next = S_DRAIN;
         S_DRAIN: if (w_dcnt_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dcnt     <= '0;
         r_ocnt     <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next != S_DRAIN);
         if (w_accept)
            r_cnt <= r_cnt + 1'b1;
         if (w_drain)
            r_dcnt <= w_dcnt_last ? '0 : r_dcnt + 1'b1;
         if (w_out_valid)
            r_ocnt <= r_ocnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl: N_POINTS=16 with STAGE=0 (D=8) and STAGE=2 (D=2).
module tb_sdf_stage_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_valid2 = 1'b0;

   logic       in_ready, delay_en, bf_sel, tw_valid, out_valid, frame_done, busy;
   logic [2:0] tw_addr;
   logic       in_ready2, delay_en2, bf_sel2, tw_valid2, out_valid2, frame_done2, busy2;
   logic [2:0] tw_addr2;

   // {in_ready, delay_en, bf_sel, tw_valid, out_valid, frame_done, busy, tw_addr}
   logic [9:0] obs, obs2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdf_stage_ctrl #(.N_POINTS(16), .STAGE(0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .delay_en(delay_en), .bf_sel(bf_sel), .tw_addr(tw_addr), .tw_valid(tw_valid),
      .out_valid(out_valid), .frame_done(frame_done), .busy(busy)
   );

   sdf_stage_ctrl #(.N_POINTS(16), .STAGE(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .delay_en(delay_en2), .bf_sel(bf_sel2), .tw_addr(tw_addr2), .tw_valid(tw_valid2),
      .out_valid(out_valid2), .frame_done(frame_done2), .busy(busy2)
   );

   assign obs  = {in_ready, delay_en, bf_sel, tw_valid, out_valid, frame_done, busy, tw_addr};
   assign obs2 = {in_ready2, delay_en2, bf_sel2, tw_valid2, out_valid2, frame_done2, busy2, tw_addr2};

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic tick(input logic r, input logic v, input logic v2);
      @(negedge clk);
      rst       = r;
      in_valid  = v;
      in_valid2 = v2;
      #1;
   endtask

   task automatic test_reset();
      for (int c = 1; c <= 3; c++) begin
         tick(1'b1, 1'b1, 1'b1);
         checks++;
         if ({obs, obs2} !== 20'd0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: got %b/%b expected all zero", c, obs, obs2);
         end
      end
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({in_ready, busy, in_ready2, busy2} !== 4'b1010) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b busy=%b rdy2=%b busy2=%b expected 1 0 1 0",
                  in_ready, busy, in_ready2, busy2);
      end
   endtask

   task automatic test_single_frame(input string tag);
      logic [9:0] e;
      int nov = 0;
      int nfd = 0;
      for (int c = 1; c <= 26; c++) begin
         tick(1'b0, (c <= 16), 1'b0);
         if (c <= 16)      e = {1'b1, 1'b1, (c >= 9), 1'b0, (c >= 9), 1'b0, (c != 1), 3'd0};
         else if (c == 17) e = {1'b1, 5'b00000, 1'b1, 3'd0};
         else if (c <= 25) e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, (c == 25), 1'b1, 3'(c - 18)};
         else              e = {1'b1, 9'd0};
         nov += int'(out_valid);
         nfd += int'(frame_done);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s cyc %0d: got %b expected %b", tag, c, obs, e);
         end
      end
      checks++;
      if (nov !== 16 || nfd !== 1) begin
         errors++;
         $display("FAIL %s_counts: got out_valid=%0d frame_done=%0d expected 16 1", tag, nov, nfd);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] e;
      logic bf, ov, tv;
      int cnt;
      int nov = 0;
      int nfd = 0;
      for (int c = 1; c <= 42; c++) begin
         tick(1'b0, (c <= 32), 1'b0);
         if (c <= 32) begin
            cnt = (c - 1) % 16;
            bf  = (cnt >= 8);
            ov  = (c >= 9);
            tv  = ov && !bf;
            e   = {1'b1, 1'b1, bf, tv, ov, (c == 24), (c != 1), tv ? 3'(cnt % 8) : 3'd0};
         end
         else if (c == 33) e = {1'b1, 5'b00000, 1'b1, 3'd0};
         else if (c <= 41) e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, (c == 41), 1'b1, 3'(c - 34)};
         else              e = {1'b1, 9'd0};
         nov += int'(out_valid);
         nfd += int'(frame_done);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: got %b expected %b", c, obs, e);
         end
      end
      checks++;
      if (nov !== 32 || nfd !== 2) begin
         errors++;
         $display("FAIL back_to_back_counts: got out_valid=%0d frame_done=%0d expected 32 2", nov, nfd);
      end
   endtask

   task automatic test_gappy();
      logic [9:0] e;
      int k;
      int nov = 0;
      int nfd = 0;
      for (int c = 1; c <= 41; c++) begin
         // odd cycles keep asserting in_valid during the drain to show it is ignored
         tick(1'b0, (c <= 40) && (c % 2 == 1), 1'b0);
         if (c <= 31 && (c % 2 == 1)) begin
            k = (c + 1) / 2;
            e = {1'b1, 1'b1, (k >= 9), 1'b0, (k >= 9), 1'b0, (k != 1), 3'd0};
         end
         else if (c <= 32) e = {1'b1, 5'b00000, 1'b1, 3'd0};
         else if (c <= 40) e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, (c == 40), 1'b1, 3'(c - 33)};
         else              e = {1'b1, 9'd0};
         nov += int'(out_valid);
         nfd += int'(frame_done);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL gappy cyc %0d: got %b expected %b", c, obs, e);
         end
      end
      checks++;
      if (nov !== 16 || nfd !== 1) begin
         errors++;
         $display("FAIL gappy_counts: got out_valid=%0d frame_done=%0d expected 16 1", nov, nfd);
      end
   endtask

   task automatic test_stage2();
      logic [9:0] e;
      logic bf, ov, tv;
      int cnt;
      int nov = 0;
      int nfd = 0;
      for (int c = 1; c <= 20; c++) begin
         tick(1'b0, 1'b0, (c <= 16));
         if (c <= 16) begin
            cnt = c - 1;
            bf  = ((cnt / 2) % 2) == 1;
            ov  = (c >= 3);
            tv  = ov && !bf;
            e   = {1'b1, 1'b1, bf, tv, ov, 1'b0, (c != 1), tv ? 3'((cnt % 2) * 4) : 3'd0};
         end
         else if (c == 17) e = {1'b1, 5'b00000, 1'b1, 3'd0};
         else if (c <= 19) e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, (c == 19), 1'b1, 3'((c - 18) * 4)};
         else              e = {1'b1, 9'd0};
         nov += int'(out_valid2);
         nfd += int'(frame_done2);
         checks++;
         if (obs2 !== e) begin
            errors++;
            $display("FAIL stage2 cyc %0d: got %b expected %b", c, obs2, e);
         end
      end
      checks++;
      if (nov !== 16 || nfd !== 1) begin
         errors++;
         $display("FAIL stage2_counts: got out_valid=%0d frame_done=%0d expected 16 1", nov, nfd);
      end
   endtask

   task automatic test_reset_in_drain();
      logic [9:0] e;
      int nov = 0;
      int nfd = 0;
      for (int c = 1; c <= 21; c++) begin
         tick((c == 21), (c <= 16), 1'b0);
         if (c <= 16)      e = {1'b1, 1'b1, (c >= 9), 1'b0, (c >= 9), 1'b0, (c != 1), 3'd0};
         else if (c == 17) e = {1'b1, 5'b00000, 1'b1, 3'd0};
         else              e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'(c - 18)};
         nov += int'(out_valid);
         nfd += int'(frame_done);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rst_drain cyc %0d: got %b expected %b", c, obs, e);
         end
      end
      tick(1'b0, 1'b0, 1'b0);
      nfd += int'(frame_done);
      checks++;
      if ({busy, out_valid, frame_done, delay_en} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_drain_abort: got busy=%b ov=%b fd=%b de=%b expected 0 0 0 0",
                  busy, out_valid, frame_done, delay_en);
      end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL rst_drain_release: got rdy=%b busy=%b expected 1 0", in_ready, busy);
      end
      checks++;
      if (nov !== 12 || nfd !== 0) begin
         errors++;
         $display("FAIL rst_drain_counts: got out_valid=%0d frame_done=%0d expected 12 0", nov, nfd);
      end
      test_single_frame("post_rst_frame");
   endtask

   initial begin
      test_reset();
      test_single_frame("single_frame");
      test_back_to_back();
      test_gappy();
      test_stage2();
      test_reset_in_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 Parameter N_POINTS, default 16: FFT frame length; power of two, >= 4.
REQ-002 Parameter STAGE, default 0: stage index, 0..log2(N_POINTS)-1; delay depth D = N_POINTS >> (STAGE+1).
REQ-003 Parameter TW_W, default log2(N_POINTS)-1: twiddle address width.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream sample present this cycle.
REQ-007 in_ready  out  1  stage accepts a sample; accept = in_valid && in_ready.
REQ-008 delay_en  out  1  shift enable for the stage's D-deep delay chain.
REQ-009 bf_sel  out  1  1 = butterfly mode (sum to output, difference into delay); 0 = bypass (input into delay, delay output to twiddle path).
REQ-010 tw_addr  out  TW_W  twiddle ROM address for the current delay-line output.
REQ-011 tw_valid  out  1  tw_addr is meaningful this cycle.
REQ-012 out_valid  out  1  stage produces a valid output sample this cycle.
REQ-013 frame_done  out  1  one-cycle pulse on the last output sample of a frame.
REQ-014 busy  out  1  state != IDLE.

Function
REQ-015 FSM states: IDLE, FILL, RUN, DRAIN; registered state, sample counter cnt (log2 N_POINTS bits), drain counter dcnt (log2 D bits, min 1), output counter ocnt (log2 N_POINTS bits).
REQ-016 in_ready is registered: 1 in IDLE/FILL/RUN, 0 in DRAIN and while rst is asserted.
REQ-017 cnt increments by 1 on every accept, wrapping N_POINTS-1 -> 0; no change otherwise.
REQ-018 IDLE -> FILL on accept; FILL -> RUN on the accept that brings cnt to D (i.e. D-th sample accepted).
REQ-019 In RUN, on accept with cnt == N_POINTS-1 (frame end): stay RUN; next frame is back-to-back if accept occurs the following cycle; otherwise RUN -> DRAIN on the first cycle after frame end with no accept.
REQ-020 Mid-frame gaps (in_valid=0, cnt != 0 after wrap) stall: no state change, delay_en=0, out_valid=0.
REQ-021 DRAIN lasts exactly D cycles (dcnt 0..D-1), then -> IDLE; in_valid ignored in DRAIN.
REQ-022 delay_en = accept || (state == DRAIN).
REQ-023 bf_sel = accept && cnt[log2 D] (bit selecting second half of each 2D block); 0 in DRAIN, IDLE, and when no accept.
REQ-024 out_valid = delay_en && (state == RUN || state == DRAIN || FILL->RUN transition cycle excluded); i.e. first out_valid is the (D+1)-th accept of a frame started from IDLE.
REQ-025 tw_valid = out_valid && !bf_sel; tw_addr = ((cnt mod D) << STAGE) in RUN, (dcnt << STAGE) in DRAIN, 0 when tw_valid=0.
REQ-026 ocnt increments on out_valid, wraps at N_POINTS; frame_done = out_valid && ocnt == N_POINTS-1.
REQ-027 Latency: stage output for input sample k appears on the out_valid cycle D accepted-or-drain cycles later.
REQ-028 Output count per frame = N_POINTS exactly, whether frames run back-to-back or end in DRAIN.
REQ-029 All outputs other than in_ready are combinational decodes of registered state/counters and in_valid; no combinational path from outputs back to in_valid.

Reset
REQ-030 While rst=1: state=IDLE, cnt=dcnt=ocnt=0, in_ready=0; hence delay_en, bf_sel, tw_valid, out_valid, frame_done, busy, tw_addr all 0.
REQ-031 rst asserted mid-frame or mid-DRAIN aborts immediately; no frame_done; first cycle after release in_ready=1, state IDLE.

Verification (N_POINTS=16, STAGE=0, D=8 unless noted)
REQ-032 Reset: rst=1 for 3 cycles with in_valid=1 -> all outputs 0; cycle after release in_ready=1, busy=0.
REQ-033 Single frame, in_valid=1 for 16 cycles then 0 -> out_valid first on accept 9, bf_sel=1 on accepts 9-16, DRAIN 8 cycles with in_ready=0, tw_addr 0..7, 16 out_valid total, frame_done on last DRAIN cycle, then IDLE.
REQ-034 Two frames back-to-back (32 continuous accepts) -> no DRAIN between frames, frame_done at accept 24 and last cycle of the single 8-cycle DRAIN, 32 out_valid total.
REQ-035 Gappy input (in_valid 1,0 alternating) -> stalls hold cnt/state, delay_en only on accepts, output count and frame_done identical to REQ-033.
REQ-036 STAGE=2 (D=2) -> bf_sel pattern 0,0,1,1 repeating, tw_addr 0,4 in bypass, DRAIN 2 cycles.
REQ-037 rst pulsed during DRAIN cycle 4 -> no frame_done, IDLE next cycle, new frame behaves as REQ-033.
